// File: rtl/decode_stage.sv
// RV32/RV64 registered decode stage with a 2-entry skid buffer.
// Define DECODE_ILLEGAL_EN to enable illegal-encoding detection.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_fmt,
    output logic            csr_instr,
    output logic            csr_imm_instr,
    output logic            illegal
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ARI_I = 7'b0010011;
    localparam logic [6:0] OP_ARI_R = 7'b0110011;
    localparam logic [6:0] OP_CSR   = 7'b1110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_fmt;
        logic            csr_instr;
        logic            csr_imm_instr;
        logic            illegal;
    } dec_t;

    logic [6:0]      op;
    logic [31:0]     imm32;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm_ext;
    logic            ill;
    dec_t            dec;
    dec_t            main_q;
    dec_t            skid_q;
    logic            main_v;
    logic            skid_v;
    logic            accept;
    logic            xfer;

    assign op = in_instr[6:0];

    // imm32 is already sign-correct at bit 31; zimm keeps bit 31 clear
    always_comb begin
        fmt   = FMT_NONE;
        imm32 = '0;
        unique case (op)
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {in_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{12{in_instr[31]}}, in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_BR: begin
                fmt   = FMT_B;
                imm32 = {{20{in_instr[31]}}, in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{21{in_instr[31]}}, in_instr[30:25],
                         in_instr[11:7]};
            end
            OP_JALR, OP_LOAD, OP_ARI_I: begin
                fmt   = FMT_I;
                imm32 = {{21{in_instr[31]}}, in_instr[30:20]};
            end
            OP_CSR: begin
                fmt   = FMT_Z;
                imm32 = {27'b0, in_instr[19:15]};
            end
            default: begin
                fmt   = FMT_NONE;
                imm32 = '0;
            end
        endcase
    end

    always_comb begin
        imm_ext       = {XLEN{imm32[31]}};
        imm_ext[31:0] = imm32;
    end

`ifdef DECODE_ILLEGAL_EN
    always_comb begin
        ill = (in_instr[1:0] != 2'b11);
        unique case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LOAD, OP_STORE, OP_ARI_I: ;
            OP_ARI_R: begin
                if (in_instr[31:25] == 7'b0100000) begin
                    if (in_instr[14:12] != 3'b000 &&
                        in_instr[14:12] != 3'b101)
                        ill = 1'b1;
                end else if (in_instr[31:25] != 7'b0000000) begin
                    ill = 1'b1;
                end
            end
            OP_BR: begin
                if (in_instr[14:13] == 2'b01)
                    ill = 1'b1;
            end
            OP_CSR: begin
                if (in_instr[14:12] == 3'b000)
                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
    end
`else
    assign ill = 1'b0;
`endif

    always_comb begin
        dec               = '0;
        dec.pc            = in_pc;
        dec.opcode        = op;
        dec.funct3        = in_instr[14:12];
        dec.funct7        = in_instr[31:25];
        dec.rd            = in_instr[11:7];
        dec.rs1           = in_instr[19:15];
        dec.rs2           = in_instr[24:20];
        dec.imm           = imm_ext;
        dec.imm_fmt       = fmt;
        dec.csr_instr     = (op == OP_CSR);
        dec.csr_imm_instr = (op == OP_CSR) & in_instr[14];
        dec.illegal       = ill;
    end

    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign accept    = in_valid & in_ready;
    assign xfer      = main_v & out_ready;

    // skid full implies in_ready=0, so no accept can race the refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (xfer) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end
        end else if (!main_v || xfer) begin
            main_v <= accept;
            if (accept)
                main_q <= dec;
        end else if (accept) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end

    assign out_pc        = main_q.pc;
    assign opcode        = main_q.opcode;
    assign funct3        = main_q.funct3;
    assign funct7        = main_q.funct7;
    assign rd            = main_q.rd;
    assign rs1           = main_q.rs1;
    assign rs2           = main_q.rs2;
    assign imm           = main_q.imm;
    assign imm_fmt       = main_q.imm_fmt;
    assign csr_instr     = main_q.csr_instr;
    assign csr_imm_instr = main_q.csr_imm_instr;
    assign illegal       = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a FIFO scoreboard of
// expected decodes; assertions at every comparison point.
module tb_decode_stage;

    localparam int XLEN = 32;
    localparam int PC_W = XLEN;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_fmt;
    logic            csr_instr;
    logic            csr_imm_instr;
    logic            illegal;

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .imm_fmt(imm_fmt), .csr_instr(csr_instr),
        .csr_imm_instr(csr_imm_instr), .illegal(illegal)
    );

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            csr;
        logic            csri;
        logic            ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v,
                                             input int bits);
        logic [XLEN-1:0] r;
        r = '0;
        for (int k = 0; k < XLEN; k++)
            r[k] = (k < bits) ? v[k] : v[bits-1];
        return r;
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] i,
                                     input logic [PC_W-1:0] pc);
        exp_t e;
        logic [6:0] o;
        logic known;
        o      = i[6:0];
        e.pc   = pc;
        e.op   = o;
        e.f3   = i[14:12];
        e.f7   = i[31:25];
        e.rd   = i[11:7];
        e.rs1  = i[19:15];
        e.rs2  = i[24:20];
        e.imm  = '0;
        e.fmt  = 3'd0;
        case (o)
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                e.imm = sext({i[31:12], 12'h000}, 32);
            end
            7'h6F: begin
                e.fmt = 3'd5;
                e.imm = sext({11'b0, i[31], i[19:12], i[20],
                              i[30:21], 1'b0}, 21);
            end
            7'h63: begin
                e.fmt = 3'd3;
                e.imm = sext({19'b0, i[31], i[7], i[30:25],
                              i[11:8], 1'b0}, 13);
            end
            7'h23: begin
                e.fmt = 3'd2;
                e.imm = sext({20'b0, i[31:25], i[11:7]}, 12);
            end
            7'h67, 7'h03, 7'h13: begin
                e.fmt = 3'd1;
                e.imm = sext({20'b0, i[31:20]}, 12);
            end
            7'h73: begin
                e.fmt = 3'd6;
                e.imm = XLEN'(i[19:15]);
            end
            default: ;
        endcase
        e.csr  = (o == 7'h73);
        e.csri = (o == 7'h73) && i[14];
        known  = o inside {7'h37, 7'h17, 7'h6F, 7'h63, 7'h23,
                           7'h67, 7'h03, 7'h13, 7'h33, 7'h73};
`ifdef DECODE_ILLEGAL_EN
        e.ill = (i[1:0] != 2'b11) || !known
             || (o == 7'h33 && !(e.f7 inside {7'h00, 7'h20}))
             || (o == 7'h33 && e.f7 == 7'h20
                 && !(e.f3 inside {3'd0, 3'd5}))
             || (o == 7'h63 && e.f3 inside {3'd2, 3'd3})
             || (o == 7'h73 && e.f3 == 3'd0);
`else
        e.ill = 1'b0;
        known = !known;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [PC_W-1:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    // scoreboard work happens at negedge, just before the handshake edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_extra_output", 64'(q.size()), 64'd1);
            end else begin
                e = q.pop_front();
                chk("sb_pc", 64'(out_pc), 64'(e.pc));
                chk("sb_opcode", 64'(opcode), 64'(e.op));
                chk("sb_funct3", 64'(funct3), 64'(e.f3));
                chk("sb_funct7", 64'(funct7), 64'(e.f7));
                chk("sb_rd", 64'(rd), 64'(e.rd));
                chk("sb_rs1", 64'(rs1), 64'(e.rs1));
                chk("sb_rs2", 64'(rs2), 64'(e.rs2));
                chk("sb_imm", 64'(imm), 64'(e.imm));
                chk("sb_fmt", 64'(imm_fmt), 64'(e.fmt));
                chk("sb_csr", 64'(csr_instr), 64'(e.csr));
                chk("sb_csri", 64'(csr_imm_instr), 64'(e.csri));
                chk("sb_illegal", 64'(illegal), 64'(e.ill));
            end
        end
        if (flush)
            q.delete();
        else if (in_valid && in_ready)
            q.push_back(ref_dec(in_instr, in_pc));
        @(posedge clk);
        #1;
    endtask

    logic [31:0]     tbl [10];
    logic [XLEN-1:0] m4;
    logic            ill0;

    initial begin
        tbl[0] = 32'hFFF00093;
        tbl[1] = 32'h0020A423;
        tbl[2] = 32'h008000EF;
        tbl[3] = 32'h00008067;
        tbl[4] = 32'h00412183;
        tbl[5] = 32'h80000217;
        tbl[6] = 32'h023100B3;
        tbl[7] = 32'h00002063;
        tbl[8] = 32'h4020F0B3;
        tbl[9] = 32'h00004501;
        m4 = '1;
        m4[1:0] = 2'b00;
`ifdef DECODE_ILLEGAL_EN
        ill0 = 1'b1;
`else
        ill0 = 1'b0;
`endif
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, '0);
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", 64'(imm), 64'd0);
        chk("rst_opcode", 64'(opcode), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_fmt", 64'(imm_fmt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        drive(1'b1, 32'h123452B7, PC_W'('h100));
        tick();
        chk("lui_valid", 64'(out_valid), 64'd1);
        chk("lui_rd", 64'(rd), 64'd5);
        chk("lui_imm", 64'(imm), 64'h12345000);
        chk("lui_fmt", 64'(imm_fmt), 64'd4);
        chk("lui_ill", 64'(illegal), 64'd0);

        drive(1'b1, 32'hFE000EE3, PC_W'('h104));
        tick();
        chk("beq_imm", 64'(imm), 64'(m4));
        chk("beq_fmt", 64'(imm_fmt), 64'd3);

        drive(1'b1, 32'h3402D073, PC_W'('h108));
        tick();
        chk("csr_instr", 64'(csr_instr), 64'd1);
        chk("csr_imm_instr", 64'(csr_imm_instr), 64'd1);
        chk("csr_imm", 64'(imm), 64'd5);
        chk("csr_fmt", 64'(imm_fmt), 64'd6);

        drive(1'b1, 32'h00000000, PC_W'('h10C));
        tick();
        chk("zero_ill", 64'(illegal), 64'(ill0));
        chk("zero_imm", 64'(imm), 64'd0);
        chk("zero_fmt", 64'(imm_fmt), 64'd0);

        drive(1'b0, 32'h0, '0);
        tick();
        chk("idle_valid", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        drive(1'b1, 32'h003100B3, PC_W'('h200));
        tick();
        drive(1'b1, 32'h40208133, PC_W'('h204));
        tick();
        drive(1'b0, 32'h0, '0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_pc_a", 64'(out_pc), 64'h200);
        tick();
        chk("bp_hold_pc", 64'(out_pc), 64'h200);
        chk("bp_hold_rd", 64'(rd), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_pc_b", 64'(out_pc), 64'h204);
        chk("bp_ready_b", 64'(in_ready), 64'd1);
        tick();
        chk("bp_drained", 64'(out_valid), 64'd0);

        for (int k = 0; k < 10; k++) begin
            drive(1'b1, tbl[k], PC_W'('h300 + 4 * k));
            tick();
            chk("stream_ready", 64'(in_ready), 64'd1);
            chk("stream_valid", 64'(out_valid), 64'd1);
        end
        drive(1'b0, 32'h0, '0);
        tick();

        out_ready = 1'b0;
        drive(1'b1, 32'h00A00513, PC_W'('h400));
        tick();
        drive(1'b1, 32'h00B00593, PC_W'('h404));
        tick();
        chk("fl_full", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h00C00613, PC_W'('h408));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, '0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);

        drive(1'b1, 32'h00D00693, PC_W'('h500));
        tick();
        drive(1'b1, 32'h00E00713, PC_W'('h504));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl2_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'h00F00793, PC_W'('h508));
        tick();
        drive(1'b0, 32'h0, '0);
        chk("fl2_pc", 64'(out_pc), 64'h508);

        for (int k = 0; k < 10 && q.size() > 0; k++)
            tick();
        chk("sb_empty", 64'(q.size()), 64'd0);
        tick();
        chk("end_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RISC-V instruction decode stage with valid/ready handshakes on both sides and a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.
- Sits between the fetch register and the execute stage.
- Splits the instruction into its fields, produces a sign-extended immediate at XLEN width and an immediate-format code, and passes the PC through.

Parameters:
- XLEN, 32, datapath width of imm/pc (32 or 64); immediates are sign-extended to XLEN.
- PC_W, XLEN, width of the pc passthrough.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction
- in_pc  in  PC_W  instruction address
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  passthrough pc
- opcode  out  7  instr[6:0]
- funct3  out  3  instr[14:12]
- funct7  out  7  instr[31:25]
- rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20]
- imm  out  XLEN  decoded immediate
- imm_fmt  out  3  0=none/R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=CSR-zimm
- csr_instr  out  1  opcode==1110011
- csr_imm_instr  out  1  csr_instr & funct3[2]
- illegal  out  1  illegal encoding (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): both entries invalid, all data registers 0, out_valid=0, all decoded outputs 0, in_ready=1 immediately after release.
- Decode is combinational on in_instr and is registered at acceptance. Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Immediate by opcode:
  - LUI 0110111, AUIPC 0010111: U format, {instr[31:12],12'b0} sign-extended.
  - JAL 1101111: J format.
  - BRANCH 1100011: B format.
  - STORE 0100011: S format.
  - JALR 1100111, LOAD 0000011, ARI_ITYPE 0010011: I format.
  - CSR 1110011: zero-extended rs1 field (zimm).
  - ARI_RTYPE 0110011 and any other opcode: imm=0, imm_fmt=0. Never X.
- Sign extension always from the top immediate bit (instr[31]) up to XLEN.
- Entries: main (drives outputs) and skid.
  - in_ready = !skid_valid.
  - Accept when in_valid & in_ready.
  - Transfer when out_valid & out_ready.
  - Main empty, or transferring with skid empty: accepted entry goes to main.
  - Main full and not transferring: accepted entry goes to skid.
  - Transfer with skid full: skid moves to main; skid freed.
  - Accept and transfer in the same cycle is allowed. Throughput is 1 per cycle when out_ready is held high.
- Outputs hold stable while out_valid & !out_ready.
- flush: at the next edge both entries are invalidated. A same-cycle accept is dropped. flush overrides all other updates. in_ready=1 on the following cycle.
- Order preserved: FIFO between skid and main.
- Data registers are not cleared by flush; only valid bits are.

Optional Feature:
- Macro DECODE_ILLEGAL_EN.
- Defined: illegal=1 when any of the following holds:
  - instr[1:0]!=2'b11
  - opcode not in the ten listed above
  - ARI_RTYPE with funct7 not in {0000000, 0100000}
  - ARI_RTYPE with funct7=0100000 and funct3 not in {000, 101}
  - BRANCH with funct3 in {010, 011}
  - CSR with funct3=000
- Illegal entries still flow through the handshake normally.
- Undefined: illegal tied 0, no detection logic.

Test Plan:
- Reset, then 0x123452B7 (LUI x5) with out_ready=1 -> next cycle out_valid=1, rd=5, imm=0x12345000, imm_fmt=4, illegal=0.
- 0xFE000EE3 (BEQ x0,x0,-4) -> imm=0xFFFFFFFC, imm_fmt=3; with XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC.
- 0x3402D073 (CSRRWI zimm=5) -> csr_instr=1, csr_imm_instr=1, imm=5, imm_fmt=6.
- out_ready=0, push A, B -> in_ready=0 after B. Raise out_ready -> A then B emitted on consecutive cycles, then in_ready=1. No loss, no duplicate.
- Main and skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle instruction never emitted.
- With DECODE_ILLEGAL_EN, 0x00000000 -> illegal=1, imm=0, imm_fmt=0. Without the macro -> illegal=0.
